// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and helpers for the OBI data-side SRAM slave and its response pipeline.
package cv32e40p_obi_pkg;

  typedef struct packed {
    logic we;
    logic err;
  } obi_resp_tok_t;

  localparam int OBI_MAX_RESP_DELAY = 3;
  localparam int OBI_DATA_W         = 32;

  // Only in-range reads carry SRAM data back; writes and errors answer with zero.
  function automatic logic [OBI_DATA_W-1:0] obi_resp_data(input obi_resp_tok_t  tok,
                                                          input logic [OBI_DATA_W-1:0] rdata);
    return (tok.we | tok.err) ? '0 : rdata;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Response pipeline: valid/token shift register of depth RESP_DELAY+1; read data joins
// at stage 0 (the SRAM's one-cycle read) and is registered through the remaining stages.
module cv32e40p_obi_resp_pipe
  import cv32e40p_obi_pkg::*;
#(
  parameter int RESP_DELAY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_push,
  input  logic        i_we,
  input  logic        i_err,
  input  logic [31:0] i_mem_rdata,
  output logic        o_vld,
  output logic        o_err,
  output logic [31:0] o_rdata
);

  localparam int DEPTH = RESP_DELAY + 1;

  logic [DEPTH-1:0] r_vld_p;
  obi_resp_tok_t    r_tok_p [DEPTH];
  logic [31:0]      w_data_p0;
  logic [31:0]      w_data_last;
  obi_resp_tok_t    w_tok_last;

  // Stage 0 .. DEPTH-1: control valids, the only state cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_push;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_tok_p[0].we  <= i_we;
    r_tok_p[0].err <= i_err;
    for (int i = 1; i < DEPTH; i++) begin
      r_tok_p[i] <= r_tok_p[i-1];
    end
  end

  assign w_data_p0 = obi_resp_data(r_tok_p[0], i_mem_rdata);

  if (RESP_DELAY == 0) begin : g_data_comb
    assign w_data_last = w_data_p0;
  end else begin : g_data_reg
    // r_data_p[k] holds the read data of stage k+1
    logic [31:0] r_data_p [RESP_DELAY];
    always_ff @(posedge clk_i) begin
      r_data_p[0] <= w_data_p0;
      for (int k = 1; k < RESP_DELAY; k++) begin
        r_data_p[k] <= r_data_p[k-1];
      end
    end
    assign w_data_last = r_data_p[RESP_DELAY-1];
  end

  // Output stage: data and error are qualified so idle/reset cycles show zero
  assign w_tok_last = r_tok_p[DEPTH-1];
  assign o_vld      = r_vld_p[DEPTH-1];
  assign o_err      = r_vld_p[DEPTH-1] & w_tok_last.err;
  assign o_rdata    = r_vld_p[DEPTH-1] ? w_data_last : '0;

endmodule

// File: rtl/cv32e40p_obi_sram_slave.sv
// OBI data-side slave terminating core requests onto a single-port 1-cycle-read SRAM,
// with range decode, bounded outstanding transfers, stall injection and delayed responses.
module cv32e40p_obi_sram_slave
  import cv32e40p_obi_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
  parameter int          RESP_DELAY      = 0,
  // Default gives full back-to-back throughput for the chosen delay
  parameter int          MAX_OUTSTANDING = RESP_DELAY + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be within 1..29");
  end
  if (RESP_DELAY < 0 || RESP_DELAY > OBI_MAX_RESP_DELAY) begin : g_bad_resp_delay
    $error("RESP_DELAY must be within 0..3");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RESP_DELAY + 1) begin : g_bad_max_out
    $error("MAX_OUTSTANDING must be within 1..RESP_DELAY+1");
  end
  if (BASE_ADDR[ADDR_WIDTH+1:0] != '0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to the SRAM size");
  end

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             w_in_range;
  logic             w_room;
  logic             w_accept;
  logic             w_rvalid;
  logic             w_unused_addr_lsb;
  logic [CNT_W-1:0] r_outstanding;

  // Byte offset within the word never reaches the SRAM
  assign w_unused_addr_lsb = ^addr_i[1:0];

  assign w_in_range = (addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  // A response popping this cycle frees a slot, so the limit never costs a bubble
  assign w_room   = (r_outstanding < MAX_CNT) | w_rvalid;
  assign gnt_o    = req_i & ~stall_i & ~rst_i & w_room;
  assign w_accept = req_i & gnt_o;

  assign mem_req_o   = w_accept & w_in_range;
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_addr_o  = addr_i[ADDR_WIDTH+1:2];
  assign mem_wdata_o = wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  cv32e40p_obi_resp_pipe #(
    .RESP_DELAY (RESP_DELAY)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (w_accept),
    .i_we        (we_i),
    .i_err       (~w_in_range),
    .i_mem_rdata (mem_rdata_i),
    .o_vld       (w_rvalid),
    .o_err       (err_o),
    .o_rdata     (rdata_o)
  );

  assign rvalid_o = w_rvalid;

endmodule

// File: tb/tb_cv32e40p_obi_sram_slave.sv
// Directed bench for the OBI SRAM slave: three instances (delay 0, 2, 3) with SRAM models.
`timescale 1ns/1ps
module tb_cv32e40p_obi_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        req0, req2, req3;

  logic        gnt0, rv0, err0, mreq0, mwe0;
  logic [3:0]  mbe0;
  logic [13:0] maddr0;
  logic [31:0] rdata0, mwdata0, mrdata0;

  logic        gnt2, rv2, err2, mreq2, mwe2;
  logic [3:0]  mbe2;
  logic [13:0] maddr2;
  logic [31:0] rdata2, mwdata2, mrdata2;

  logic        gnt3, rv3, err3, mreq3, mwe3;
  logic [3:0]  mbe3;
  logic [13:0] maddr3;
  logic [31:0] rdata3, mwdata3, mrdata3;

  cv32e40p_obi_sram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0010_0000), .RESP_DELAY(0), .MAX_OUTSTANDING(1)) u0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req0), .gnt_o(gnt0), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv0), .rdata_o(rdata0), .err_o(err0),
    .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(mbe0), .mem_addr_o(maddr0),
    .mem_wdata_o(mwdata0), .mem_rdata_i(mrdata0));

  cv32e40p_obi_sram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0010_0000), .RESP_DELAY(2), .MAX_OUTSTANDING(2)) u2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req2), .gnt_o(gnt2), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv2), .rdata_o(rdata2), .err_o(err2),
    .mem_req_o(mreq2), .mem_we_o(mwe2), .mem_be_o(mbe2), .mem_addr_o(maddr2),
    .mem_wdata_o(mwdata2), .mem_rdata_i(mrdata2));

  cv32e40p_obi_sram_slave #(.ADDR_WIDTH(14), .BASE_ADDR(32'h0010_0000), .RESP_DELAY(3), .MAX_OUTSTANDING(2)) u3 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req3), .gnt_o(gnt3), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rv3), .rdata_o(rdata3), .err_o(err3),
    .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_addr_o(maddr3),
    .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3));

  // Byte-writable SRAM behind u0; u2/u3 see a read-only pattern 0x5A00_0000 | word address
  logic [31:0] mem0 [16384];
  always @(posedge clk) begin
    if (mreq0) begin
      if (mwe0) begin
        for (int b = 0; b < 4; b++)
          if (mbe0[b]) mem0[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
      end else begin
        mrdata0 <= mem0[maddr0];
      end
    end
  end
  always @(posedge clk) if (mreq2 && !mwe2) mrdata2 <= 32'h5A00_0000 | {18'h0, maddr2};
  always @(posedge clk) if (mreq3 && !mwe3) mrdata3 <= 32'h5A00_0000 | {18'h0, maddr3};

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ex_mreq;
    logic [13:0] ex_maddr;
    logic [31:0] ex_rdata;
    logic        ex_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] d, input logic mr, input logic [13:0] ma,
                              input logic [31:0] rd, input logic e);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = d;
    v.ex_mreq = mr; v.ex_maddr = ma; v.ex_rdata = rd; v.ex_err = e;
    return v;
  endfunction

  vec_t vt [13];
  int expg [12];
  int expv [12];
  int ridx, nacc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mk(1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 1, 14'h0004, 32'h0000_0000, 0);
    vt[1]  = mk(0, 4'hF, 32'h0010_0010, 32'h0,         1, 14'h0004, 32'hDEAD_BEEF, 0);
    vt[2]  = mk(1, 4'hF, 32'h0010_0020, 32'hFFFF_FFFF, 1, 14'h0008, 32'h0000_0000, 0);
    vt[3]  = mk(1, 4'h3, 32'h0010_0020, 32'h1234_5678, 1, 14'h0008, 32'h0000_0000, 0);
    vt[4]  = mk(0, 4'hF, 32'h0010_0020, 32'h0,         1, 14'h0008, 32'hFFFF_5678, 0);
    vt[5]  = mk(0, 4'hF, 32'h0000_0000, 32'h0,         0, 14'h0000, 32'h0000_0000, 1);
    vt[6]  = mk(0, 4'hF, 32'h0011_0000, 32'h0,         0, 14'h0000, 32'h0000_0000, 1);
    vt[7]  = mk(1, 4'hF, 32'h0010_FFFC, 32'hA5A5_0001, 1, 14'h3FFF, 32'h0000_0000, 0);
    vt[8]  = mk(0, 4'hF, 32'h0010_FFFF, 32'h0,         1, 14'h3FFF, 32'hA5A5_0001, 0);
    vt[9]  = mk(1, 4'h4, 32'h0010_0012, 32'h0077_0000, 1, 14'h0004, 32'h0000_0000, 0);
    vt[10] = mk(0, 4'hF, 32'h0010_0011, 32'h0,         1, 14'h0004, 32'hDE77_BEEF, 0);
    vt[11] = mk(1, 4'hF, 32'h0011_0000, 32'h1111_1111, 0, 14'h0000, 32'h0000_0000, 1);
    vt[12] = mk(0, 4'hF, 32'h000F_FFFC, 32'h0,         0, 14'h0000, 32'h0000_0000, 1);

    expg = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    expv = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

    // Reset with requests pending: nothing may be granted or reach the SRAM
    rst = 1; stall = 0; we = 0; be = 4'hF; addr = 32'h0010_0000; wdata = '0;
    req0 = 1; req2 = 1; req3 = 1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_gnt0", {31'h0, gnt0}, 32'h0);
    chk("rst_gnt2", {31'h0, gnt2}, 32'h0);
    chk("rst_gnt3", {31'h0, gnt3}, 32'h0);
    chk("rst_mreq0", {31'h0, mreq0}, 32'h0);
    chk("rst_rv0", {31'h0, rv0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_err0", {31'h0, err0}, 32'h0);
    chk("rst_rv3", {31'h0, rv3}, 32'h0);
    step();
    rst = 0; req0 = 0; req2 = 0; req3 = 0;
    step();

    // Single transfers on the zero-delay instance
    for (int i = 0; i < 13; i++) begin
      req0 = 1; we = vt[i].we; be = vt[i].be; addr = vt[i].addr; wdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {31'h0, gnt0}, 32'h1);
      chk($sformatf("v%0d_mreq", i), {31'h0, mreq0}, {31'h0, vt[i].ex_mreq});
      if (vt[i].ex_mreq) begin
        chk($sformatf("v%0d_maddr", i), {18'h0, maddr0}, {18'h0, vt[i].ex_maddr});
        chk($sformatf("v%0d_mbe", i), {28'h0, mbe0}, {28'h0, vt[i].be});
        chk($sformatf("v%0d_mwe", i), {31'h0, mwe0}, {31'h0, vt[i].we});
        if (vt[i].we) chk($sformatf("v%0d_mwdata", i), mwdata0, vt[i].wdata);
      end
      chk($sformatf("v%0d_rv_early", i), {31'h0, rv0}, 32'h0);
      step();
      req0 = 0;
      @(negedge clk);
      chk($sformatf("v%0d_rv", i), {31'h0, rv0}, 32'h1);
      chk($sformatf("v%0d_rdata", i), rdata0, vt[i].ex_rdata);
      chk($sformatf("v%0d_err", i), {31'h0, err0}, {31'h0, vt[i].ex_err});
      step();
    end

    // Stall for 5 cycles over a pending read, grant on the first free cycle
    we = 0; be = 4'hF; addr = 32'h0010_0010; req0 = 1; stall = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_gnt", c), {31'h0, gnt0}, 32'h0);
      chk($sformatf("stall%0d_mreq", c), {31'h0, mreq0}, 32'h0);
      chk($sformatf("stall%0d_rv", c), {31'h0, rv0}, 32'h0);
      step();
    end
    stall = 0;
    @(negedge clk);
    chk("stall_rel_gnt", {31'h0, gnt0}, 32'h1);
    chk("stall_rel_mreq", {31'h0, mreq0}, 32'h1);
    step();
    req0 = 0;
    @(negedge clk);
    chk("stall_rv", {31'h0, rv0}, 32'h1);
    chk("stall_rdata", rdata0, 32'hDE77_BEEF);
    step();

    // Outstanding limit: delay 3, limit 2, request held for 8 cycles
    ridx = 0; nacc = 0; we = 0;
    for (int c = 0; c < 12; c++) begin
      req3 = (c < 8);
      addr = 32'h0010_0000 + 32'(4 * nacc);
      @(negedge clk);
      chk($sformatf("lim%0d_gnt", c), {31'h0, gnt3}, 32'(expg[c]));
      chk($sformatf("lim%0d_rv", c), {31'h0, rv3}, 32'(expv[c]));
      if (expv[c] != 0) begin
        chk($sformatf("lim%0d_rdata", c), rdata3, 32'h5A00_0000 + 32'(ridx));
        ridx++;
      end
      if (expg[c] != 0) nacc++;
      step();
    end
    req3 = 0;

    // Out-of-range read on the delay-3 instance: error after 4 cycles, no SRAM strobe
    addr = 32'h0011_0000; req3 = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("oor3_gnt", {31'h0, gnt3}, 32'h1);
        chk("oor3_mreq", {31'h0, mreq3}, 32'h0);
      end
      chk($sformatf("oor3_rv%0d", c), {31'h0, rv3}, (c == 4) ? 32'h1 : 32'h0);
      if (c == 4) begin
        chk("oor3_err", {31'h0, err3}, 32'h1);
        chk("oor3_rdata", rdata3, 32'h0);
      end
      step();
      req3 = 0;
    end

    // Mid-operation reset with two reads in flight on the delay-2 instance
    req2 = 1; addr = 32'h0010_0040;
    @(negedge clk);
    chk("mrst_gnt_a", {31'h0, gnt2}, 32'h1);
    step();
    addr = 32'h0010_0044;
    @(negedge clk);
    chk("mrst_gnt_b", {31'h0, gnt2}, 32'h1);
    step();
    req2 = 0; rst = 1;
    @(negedge clk);
    chk("mrst_rv_c2", {31'h0, rv2}, 32'h0);
    step();
    rst = 0;
    for (int c = 3; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_rv_c%0d", c), {31'h0, rv2}, 32'h0);
      step();
    end
    req2 = 1; addr = 32'h0010_0048;
    @(negedge clk);
    chk("mrst_gnt_c", {31'h0, gnt2}, 32'h1);
    step();
    addr = 32'h0010_004C;
    @(negedge clk);
    chk("mrst_gnt_d", {31'h0, gnt2}, 32'h1);
    step();
    req2 = 0;
    for (int c = 9; c < 13; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_post_rv%0d", c), {31'h0, rv2}, (c == 10 || c == 11) ? 32'h1 : 32'h0);
      if (c == 10) chk("mrst_post_rdata_c", rdata2, 32'h5A00_0012);
      if (c == 11) chk("mrst_post_rdata_d", rdata2, 32'h5A00_0013);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
